// File: rtl/s4ga_fabric.sv
// s4ga_fabric: serially configured, time-multiplexed LUT fabric.
// N LUTs of K inputs are loaded through a W-bit shift chain. In run mode one LUT
// is evaluated per clock, round-robin, into a registered output bank that also
// feeds back as LUT inputs.
module s4ga_fabric #(
  parameter int N = 8,
  parameter int K = 4,
  parameter int W = 4,
  parameter int I = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg,
  input  logic [W-1:0] si,
  input  logic [I-1:0] ins,
  output logic [N-1:0] luts,
  output logic         loaded,
  output logic         frame
);

  localparam int SELW     = $clog2(N + I);
  localparam int TTB      = 2 ** K;
  localparam int FRAME    = TTB + K * SELW;
  localparam int CFG_BITS = N * FRAME;
  localparam int CFG_CYC  = (CFG_BITS + W - 1) / W;
  localparam int CHAIN    = CFG_CYC * W;
  localparam int IDXW     = $clog2(N);
  localparam int CNTW     = $clog2(CFG_CYC + 1);

  logic [CHAIN-1:0] chain;
  logic [IDXW-1:0]  idx;
  logic [CNTW-1:0]  cnt;
  logic             cfg_q;

  logic [FRAME-1:0] cur;
  logic [TTB-1:0]   tt;
  logic [K-1:0]     addr;
  logic             eval_bit;
  logic [CNTW-1:0]  cnt_nxt;
  logic             last;

  // Selector decode: LUT outputs first, then external inputs, anything above reads 0.
  function automatic logic sel_decode(input logic [SELW-1:0] s,
                                      input logic [N-1:0]    l,
                                      input logic [I-1:0]    x);
    logic b;
    b = 1'b0;
    for (int m = 0; m < N; m++)
      if (s == SELW'(m)) b = l[m];
    for (int m = 0; m < I; m++)
      if (s == SELW'(N + m)) b = x[m];
    return b;
  endfunction

  // Pick out the configuration frame of the LUT currently being evaluated.
  always_comb begin
    cur = '0;
    for (int j = 0; j < N; j++)
      if (idx == IDXW'(j)) cur = chain[j*FRAME +: FRAME];
  end

  // Gather the K selected inputs and look up the truth table.
  always_comb begin
    addr = '0;
    for (int k = 0; k < K; k++)
      addr[k] = sel_decode(cur[TTB + k*SELW +: SELW], luts, ins);
    tt       = cur[TTB-1:0];
    eval_bit = tt[addr];
  end

  // Config word count: restart at 1 on cfg entry, saturate at a full load.
  always_comb begin
    if (!cfg_q)
      cnt_nxt = CNTW'(1);
    else if (cnt == CNTW'(CFG_CYC))
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + CNTW'(1);
    last = (idx == IDXW'(N - 1));
  end

  // Shift chain, load tracking, round-robin evaluation and sweep pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain  <= '0;
      luts   <= '0;
      idx    <= '0;
      cnt    <= '0;
      loaded <= 1'b0;
      frame  <= 1'b0;
      cfg_q  <= 1'b0;
    end else begin
      cfg_q <= cfg;
      if (cfg) begin
        chain <= {si, chain[CHAIN-1:W]};
        cnt   <= cnt_nxt;
        if (cnt_nxt == CNTW'(CFG_CYC))
          loaded <= 1'b1;
        else if (!cfg_q)
          loaded <= 1'b0;
        idx   <= '0;
        frame <= 1'b0;
      end else if (loaded) begin
        luts[idx] <= eval_bit;
        frame     <= last;
        idx       <= last ? '0 : idx + IDXW'(1);
      end else begin
        idx   <= '0;
        frame <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_s4ga_fabric.sv
// Testbench for s4ga_fabric: directed scenarios plus randomized configurations,
// each cycle checked against a behavioural model of the fabric.
module tb_s4ga_fabric;

  localparam int N        = 8;
  localparam int K        = 4;
  localparam int W        = 4;
  localparam int I        = 4;
  localparam int SELW     = $clog2(N + I);
  localparam int TTB      = 1 << K;
  localparam int FRAME    = TTB + K * SELW;
  localparam int CFG_BITS = N * FRAME;
  localparam int CFG_CYC  = (CFG_BITS + W - 1) / W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg = 1'b0;
  logic [W-1:0] si  = '0;
  logic [I-1:0] ins = '0;
  logic [N-1:0] luts;
  logic         loaded;
  logic         frame;

  s4ga_fabric #(.N(N), .K(K), .W(W), .I(I)) dut (
    .clk(clk), .rst(rst), .cfg(cfg), .si(si), .ins(ins),
    .luts(luts), .loaded(loaded), .frame(frame)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: words received (newest last), LUT bank, sweep position.
  logic [W-1:0]   wq[$];
  logic [N-1:0]   m_luts;
  bit             m_loaded, m_frame, m_cfgq;
  int             m_idx, m_cnt;

  // Intended configuration used to build the bitstream.
  logic [TTB-1:0] c_tt[N];
  int             c_sel[N][K];

  // Bit b of the chain: the chain holds the last CFG_CYC words, oldest lowest.
  function automatic bit chain_bit(input int b);
    int qi;
    qi = wq.size() - CFG_CYC + b / W;
    if (qi < 0) return 1'b0;
    return wq[qi][b % W];
  endfunction

  function automatic int chain_field(input int lo, input int w);
    int v;
    v = 0;
    for (int i = 0; i < w; i++) v |= int'(chain_bit(lo + i)) << i;
    return v;
  endfunction

  task automatic model_reset();
    wq.delete();
    m_luts = '0; m_loaded = 0; m_frame = 0; m_cfgq = 0; m_idx = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit c, input logic [W-1:0] s, input logic [I-1:0] x);
    int sv, addr;
    bit b, v;
    if (c) begin
      if (!m_cfgq) begin m_cnt = 1; m_loaded = 0; end
      else if (m_cnt < CFG_CYC) m_cnt++;
      if (m_cnt == CFG_CYC) m_loaded = 1;
      wq.push_back(s);
      if (wq.size() > CFG_CYC) void'(wq.pop_front());
      m_idx = 0; m_frame = 0;
    end else if (m_loaded) begin
      addr = 0;
      for (int k = 0; k < K; k++) begin
        sv = chain_field(m_idx*FRAME + TTB + k*SELW, SELW);
        if (sv < N) b = m_luts[sv];
        else if (sv < N + I) b = x[sv-N];
        else b = 1'b0;
        addr |= int'(b) << k;
      end
      v = chain_bit(m_idx*FRAME + addr);
      m_frame = (m_idx == N - 1);
      m_luts[m_idx] = v;
      m_idx = (m_idx + 1) % N;
    end else begin
      m_idx = 0; m_frame = 0;
    end
    m_cfgq = c;
  endtask

  task automatic cycle(input bit c, input logic [W-1:0] s, input logic [I-1:0] x, input string tag);
    cfg = c; si = s; ins = x;
    @(posedge clk);
    model_edge(c, s, x);
    #1;
    chk({tag, ".luts"},   32'(luts),   32'(m_luts));
    chk({tag, ".loaded"}, 32'(loaded), 32'(m_loaded));
    chk({tag, ".frame"},  32'(frame),  32'(m_frame));
  endtask

  task automatic load(input string tag);
    logic [CFG_CYC*W-1:0] bs;
    bs = '0;
    for (int j = 0; j < N; j++) begin
      bs[j*FRAME +: TTB] = c_tt[j];
      for (int k = 0; k < K; k++)
        bs[j*FRAME + TTB + k*SELW +: SELW] = SELW'(c_sel[j][k]);
    end
    for (int w = 0; w < CFG_CYC; w++)
      cycle(1'b1, bs[w*W +: W], I'($urandom), tag);
    chk({tag, ".done"}, 32'(loaded), 32'd1);
  endtask

  task automatic run(input int n, input bit rnd, input string tag);
    for (int i = 0; i < n; i++)
      cycle(1'b0, '0, rnd ? I'($urandom) : I'(0), tag);
  endtask

  task automatic set_all(input logic [TTB-1:0] t, input int s0);
    for (int j = 0; j < N; j++) begin
      c_tt[j] = t;
      c_sel[j][0] = s0;
      for (int k = 1; k < K; k++) c_sel[j][k] = 15;
    end
  endtask

  task automatic set_ring();
    set_all(16'hAAAA, 0);
    c_tt[0] = 16'h5555;
    c_sel[0][0] = N - 1;
    for (int j = 1; j < N; j++) c_sel[j][0] = j - 1;
  endtask

  logic [N-1:0] held;
  logic [N-1:0] ring_exp;

  initial begin
    // Reset held low
    #2 rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.luts",   32'(luts),   32'h00);
    chk("rst.loaded", 32'(loaded), 32'h0);
    chk("rst.frame",  32'(frame),  32'h0);
    rst = 1'b1;
    run(4, 1'b1, "rst_rel");

    // All LUTs pass through inverted ins[0]
    set_all(16'h5555, N);
    load("t2_load");
    run(N, 1'b0, "t2_run");
    chk("t2.luts_ff", 32'(luts),  32'hFF);
    chk("t2.frame",   32'(frame), 32'h1);
    run(1, 1'b0, "t2_after");

    // Ring oscillator: alternates each sweep
    set_ring();
    load("t3_load");
    ring_exp = 8'h00;
    for (int s = 0; s < 4; s++) begin
      run(N, 1'b0, "t3_run");
      chk("t3.ring", 32'(luts), 32'(ring_exp));
      chk("t3.pulse", 32'(frame), 32'h1);
      ring_exp = ~ring_exp;
    end

    // Interrupt a sweep at idx=3 with a new load
    run(3, 1'b0, "t4_pre");
    held = luts;
    cycle(1'b1, '0, '0, "t4_first");
    chk("t4.loaded_drop", 32'(loaded), 32'h0);
    chk("t4.held",        32'(luts),   32'(held));
    cycle(1'b0, '0, '0, "t4_gap");
    load("t4_load");
    chk("t4.held_after", 32'(luts), 32'(held));
    run(2 * N, 1'b0, "t4_run");

    // Out-of-range selector reads 0
    set_ring();
    c_tt[0] = 16'hAAAA;
    for (int k = 0; k < K; k++) c_sel[0][k] = 15;
    load("t5a_load");
    run(1, 1'b1, "t5a_run");
    chk("t5.oor_aaaa", 32'(luts[0]), 32'h0);
    c_tt[0] = 16'h5555;
    load("t5b_load");
    run(1, 1'b1, "t5b_run");
    chk("t5.oor_5555", 32'(luts[0]), 32'h1);

    // Async reset between clock edges mid-sweep
    set_all(16'h5555, N);
    load("t6_load");
    run(N + 3, 1'b0, "t6_pre");
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t6.luts",   32'(luts),   32'h00);
    chk("t6.loaded", 32'(loaded), 32'h0);
    chk("t6.frame",  32'(frame),  32'h0);
    #2 rst = 1'b1;
    run(12, 1'b1, "t6_noeval");

    // Randomized configurations, extra words, random inputs
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < N; j++) begin
        c_tt[j] = TTB'($urandom);
        for (int k = 0; k < K; k++) c_sel[j][k] = $urandom_range(0, 15);
      end
      load("rnd_load");
      for (int e = $urandom_range(0, 2); e > 0; e--)
        cycle(1'b1, W'($urandom), I'($urandom), "rnd_extra");
      run($urandom_range(10, 30), 1'b1, "rnd_run");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
